// File: rtl/sprite_line_writer.sv
// Sprite line renderer: scans the sprite attribute RAM for the line being
// prepared and writes opaque pixels of every hitting sprite into one half of
// the sprite line double buffer. Sprites run from NSPR-1 down to 0, so sprite 0
// is written last and ends up on top.
//
// Ports:
//   CL, RSTn           clock, asynchronous active-low reset
//   HSTART, VPOS, BANK start pulse, line number and buffer half (sampled on start)
//   SA / SD            attribute RAM address out, combinational read data in
//   CREQ, CA / CACK,CD pattern fetch handshake: {code,row,half} out, 8 pixels in
//   LA, LD, LWE        registered line buffer write port {bank,x} / {pal,pix}
//   BUSY, DONE         render in progress, one-cycle completion pulse
module sprite_line_writer #(
   parameter int unsigned NSPR = 32
) (
   input  logic        CL,
   input  logic        RSTn,
   input  logic        HSTART,
   input  logic [7:0]  VPOS,
   input  logic        BANK,
   output logic [6:0]  SA,
   input  logic [7:0]  SD,
   output logic        CREQ,
   output logic [14:0] CA,
   input  logic        CACK,
   input  logic [31:0] CD,
   output logic [9:0]  LA,
   output logic [6:0]  LD,
   output logic        LWE,
   output logic        BUSY,
   output logic        DONE
);

   localparam int unsigned IDX_W = 5;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSPR - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ATTR,
      S_CHECK,
      S_FETCH,
      S_DRAW,
      S_NEXT
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        k_q, k_d;
   logic [2:0]        pix_q, pix_d;
   logic              half_q, half_d;
   logic [7:0]        vpos_q, vpos_d;
   logic              bank_q, bank_d;
   logic [7:0]        y_q, y_d;
   logic [7:0]        code_lo_q, code_lo_d;
   logic [6:0]        attr_q, attr_d;
   logic [7:0]        x_q, x_d;
   logic [31:0]       pat_q, pat_d;
   logic [6:0]        sa_q, sa_d;
   logic              creq_q, creq_d;
   logic [14:0]       ca_q, ca_d;
   logic [9:0]        la_q, la_d;
   logic [6:0]        ld_q, ld_d;
   logic              lwe_q, lwe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [7:0]        row;
   logic [3:0]        row_eff;
   logic [3:0]        nib;
   logic [8:0]        s;

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      k_d       = k_q;
      pix_d     = pix_q;
      half_d    = half_q;
      vpos_d    = vpos_q;
      bank_d    = bank_q;
      y_d       = y_q;
      code_lo_d = code_lo_q;
      attr_d    = attr_q;
      x_d       = x_q;
      pat_d     = pat_q;
      sa_d      = sa_q;
      creq_d    = creq_q;
      ca_d      = ca_q;
      la_d      = la_q;
      ld_d      = ld_q;
      lwe_d     = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;

      // Row within the sprite wraps mod 256; 15-row is the 4-bit complement
      row     = vpos_q - y_q;
      row_eff = attr_q[2] ? ~row[3:0] : row[3:0];
      // flipX reads the captured word right to left
      nib     = attr_q[3] ? pat_q[{pix_q, 2'b00} +: 4]
                          : pat_q[5'd28 - {pix_q, 2'b00} +: 4];
      // Screen offset is 8*half_index + pixel
      s       = {1'b0, x_q} + {5'b0, half_q, pix_q};

      unique case (state_q)
         S_IDLE: begin
            if (HSTART) begin
               vpos_d  = VPOS;
               bank_d  = BANK;
               busy_d  = 1'b1;
               idx_d   = IDX_LAST;
               k_d     = 2'd0;
               sa_d    = {IDX_LAST, 2'b00};
               state_d = S_ATTR;
            end
         end
         S_ATTR: begin
            unique case (k_q)
               2'd0:    y_d       = SD;
               2'd1:    code_lo_d = SD;
               2'd2:    attr_d    = SD[6:0];
               default: x_d       = SD;
            endcase
            if (k_q == 2'd3) begin
               state_d = S_CHECK;
            end else begin
               k_d  = k_q + 2'd1;
               sa_d = {idx_q, k_q + 2'd1};
            end
         end
         S_CHECK: begin
            if (row[7:4] == 4'd0) begin
               creq_d  = 1'b1;
               ca_d    = {attr_q[1:0], code_lo_q, row_eff, attr_q[3]};
               half_d  = 1'b0;
               state_d = S_FETCH;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_FETCH: begin
            if (CACK) begin
               pat_d   = CD;
               creq_d  = 1'b0;
               pix_d   = 3'd0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            lwe_d = (nib != 4'd0) && !s[8];
            la_d  = {bank_q, s};
            ld_d  = {attr_q[6:4], nib};
            if (pix_q == 3'd7) begin
               if (!half_q) begin
                  // Second half of the row: same code/row, other pattern half
                  half_d  = 1'b1;
                  creq_d  = 1'b1;
                  ca_d    = {ca_q[14:1], ~ca_q[0]};
                  state_d = S_FETCH;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               pix_d = pix_q + 3'd1;
            end
         end
         S_NEXT: begin
            if (idx_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q - IDX_W'(1);
               k_d     = 2'd0;
               sa_d    = {idx_q - IDX_W'(1), 2'b00};
               state_d = S_ATTR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any line in progress
   always_ff @(posedge CL or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         k_q       <= '0;
         pix_q     <= '0;
         half_q    <= 1'b0;
         vpos_q    <= '0;
         bank_q    <= 1'b0;
         y_q       <= '0;
         code_lo_q <= '0;
         attr_q    <= '0;
         x_q       <= '0;
         pat_q     <= '0;
         sa_q      <= '0;
         creq_q    <= 1'b0;
         ca_q      <= '0;
         la_q      <= '0;
         ld_q      <= '0;
         lwe_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         k_q       <= k_d;
         pix_q     <= pix_d;
         half_q    <= half_d;
         vpos_q    <= vpos_d;
         bank_q    <= bank_d;
         y_q       <= y_d;
         code_lo_q <= code_lo_d;
         attr_q    <= attr_d;
         x_q       <= x_d;
         pat_q     <= pat_d;
         sa_q      <= sa_d;
         creq_q    <= creq_d;
         ca_q      <= ca_d;
         la_q      <= la_d;
         ld_q      <= ld_d;
         lwe_q     <= lwe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign SA   = sa_q;
   assign CREQ = creq_q;
   assign CA   = ca_q;
   assign LA   = la_q;
   assign LD   = ld_q;
   assign LWE  = lwe_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_sprite_line_writer.sv
// Bench for sprite_line_writer: attribute RAM and pattern ROM models, a
// reference model that lists every expected fetch and pixel write per line,
// and independent monitors that compare what the DUT presents against it.
module tb_sprite_line_writer;

   localparam int NSPR = 32;

   logic        CL = 1'b0;
   logic        RSTn;
   logic        HSTART;
   logic [7:0]  VPOS;
   logic        BANK;
   logic [6:0]  SA;
   logic [7:0]  SD;
   logic        CREQ;
   logic [14:0] CA;
   logic        CACK;
   logic [31:0] CD;
   logic [9:0]  LA;
   logic [6:0]  LD;
   logic        LWE;
   logic        BUSY;
   logic        DONE;

   int total = 0;
   int bad   = 0;

   logic [7:0]  attr_ram [128];
   int          rom_mode;
   logic [31:0] rom_seed;
   int          lat;
   bit          stray_en;

   logic [16:0] exp_wr [$];
   logic [14:0] exp_ca [$];
   logic [7:0]  model_buf [1024];
   logic [7:0]  dut_buf   [1024];

   sprite_line_writer #(.NSPR(NSPR)) dut (
      .CL(CL), .RSTn(RSTn), .HSTART(HSTART), .VPOS(VPOS), .BANK(BANK),
      .SA(SA), .SD(SD), .CREQ(CREQ), .CA(CA), .CACK(CACK), .CD(CD),
      .LA(LA), .LD(LD), .LWE(LWE), .BUSY(BUSY), .DONE(DONE)
   );

   assign SD = attr_ram[SA];

   always #5 CL = ~CL;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rom(input logic [14:0] a);
      logic [31:0] h;
      case (rom_mode)
         0:       return 32'h1234_5670;
         1:       return 32'h9ABC_DEF1;
         default: begin
            h = (32'(a) * 32'h9E37_79B1) ^ rom_seed;
            h = h ^ (h >> 13);
            return h & 32'hF7F3_7F3F;
         end
      endcase
   endfunction

   // Reference: every sprite hitting the line contributes a 16-pixel row;
   // screen column o shows pattern column c (mirrored under flipX), and
   // pattern column c lives in ROM half c/8, nibble c%8 from the left.
   task automatic build_line(input logic [7:0] vp, input logic bk, output int exp_cycles);
      logic [7:0]  y, x;
      logic [9:0]  code;
      logic [2:0]  pal;
      logic        fx, fy;
      logic [31:0] w;
      logic [3:0]  nib;
      int          row, r, c, sx, hits;
      hits = 0;
      for (int n = NSPR - 1; n >= 0; n--) begin
         y    = attr_ram[4*n];
         code = {attr_ram[4*n+2][1:0], attr_ram[4*n+1]};
         pal  = attr_ram[4*n+2][6:4];
         fx   = attr_ram[4*n+2][3];
         fy   = attr_ram[4*n+2][2];
         x    = attr_ram[4*n+3];
         row  = int'(vp) - int'(y);
         if (row < 0) row += 256;
         if (row < 16) begin
            hits++;
            r = fy ? 15 - row : row;
            exp_ca.push_back({code, 4'(r), fx});
            exp_ca.push_back({code, 4'(r), ~fx});
            for (int o = 0; o < 16; o++) begin
               c   = fx ? 15 - o : o;
               w   = rom({code, 4'(r), 1'(c / 8)});
               nib = 4'(w >> (28 - 4 * (c % 8)));
               sx  = int'(x) + o;
               if (sx < 256 && nib != 4'd0) begin
                  exp_wr.push_back({bk, 9'(sx), pal, nib});
                  model_buf[{bk, 9'(sx)}] = {1'b0, pal, nib};
               end
            end
         end
      end
      exp_cycles = 6 * NSPR + hits * 2 * (8 + lat);
   endtask

   task automatic clear_attr();
      for (int n = 0; n < NSPR; n++) begin
         attr_ram[4*n]   = 8'hF0;
         attr_ram[4*n+1] = 8'h00;
         attr_ram[4*n+2] = 8'h00;
         attr_ram[4*n+3] = 8'h00;
      end
   endtask

   task automatic set_spr(input int n, input logic [7:0] y, input logic [9:0] code,
                          input logic [2:0] pal, input logic fx, input logic fy, input logic [7:0] x);
      attr_ram[4*n]   = y;
      attr_ram[4*n+1] = code[7:0];
      attr_ram[4*n+2] = {1'b0, pal, fx, fy, code[9:8]};
      attr_ram[4*n+3] = x;
   endtask

   task automatic fill_random(input logic [7:0] vp);
      for (int n = 0; n < NSPR; n++) begin
         attr_ram[4*n]   = vp - 8'($urandom_range(0, 31));
         attr_ram[4*n+1] = 8'($urandom);
         attr_ram[4*n+2] = 8'($urandom);
         attr_ram[4*n+3] = 8'($urandom);
      end
   endtask

   task automatic start_line(input logic [7:0] vp, input logic bk, output int exp_cycles);
      for (int i = 0; i < 1024; i++) begin
         model_buf[i] = 8'hFF;
         dut_buf[i]   = 8'hFF;
      end
      build_line(vp, bk, exp_cycles);
      VPOS   = vp;
      BANK   = bk;
      HSTART = 1'b1;
      @(posedge CL); #1;
      HSTART = 1'b0;
      VPOS   = ~vp;
      BANK   = ~bk;
      check("busy_rise", 32'(BUSY), 32'd1);
   endtask

   task automatic run_line(input logic [7:0] vp, input logic bk, input bit poke);
      int cnt, exp_cycles, diff;
      start_line(vp, bk, exp_cycles);
      cnt = 0;
      while (DONE !== 1'b1 && cnt < 4000) begin
         @(posedge CL); #1;
         cnt++;
         if (poke && cnt == 40) begin
            HSTART = 1'b1;
            VPOS   = vp + 8'd1;
         end
         if (poke && cnt == 41) HSTART = 1'b0;
      end
      check("done_time", 32'(cnt), 32'(exp_cycles));
      check("busy_fall", 32'(BUSY), 32'd0);
      @(posedge CL); #1;
      check("done_pulse", 32'(DONE), 32'd0);
      check("writes_left", 32'(exp_wr.size()), 32'd0);
      check("fetch_left", 32'(exp_ca.size()), 32'd0);
      diff = 0;
      for (int i = 0; i < 1024; i++) if (dut_buf[i] !== model_buf[i]) diff++;
      check("linebuf", 32'(diff), 32'd0);
      exp_wr.delete();
      exp_ca.delete();
   endtask

   // Write monitor: every LWE must match the next expected write
   initial begin
      logic [16:0] e;
      forever begin
         @(posedge CL); #1;
         if (LWE === 1'b1) begin
            dut_buf[LA] = {1'b0, LD};
            if (exp_wr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL write actual=%0h required=none", {LA, LD});
            end else begin
               e = exp_wr.pop_front();
               check("write", 32'({LA, LD}), 32'(e));
            end
         end
      end
   end

   // Pattern ROM: answers CREQ after lat cycles, checks the address,
   // and optionally throws stray CACKs while no request is pending
   initial begin
      int fw;
      CACK = 1'b0;
      CD   = '0;
      fw   = 0;
      forever begin
         @(posedge CL); #1;
         CACK = 1'b0;
         if (CREQ === 1'b1 && RSTn === 1'b1) begin
            fw++;
            if (fw >= lat) begin
               fw   = 0;
               CACK = 1'b1;
               CD   = rom(CA);
               if (exp_ca.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL fetch actual=%0h required=none", CA);
               end else begin
                  check("fetch_addr", 32'(CA), 32'(exp_ca.pop_front()));
               end
            end
         end else begin
            fw = 0;
            if (stray_en && $urandom_range(0, 7) == 0) begin
               CACK = 1'b1;
               CD   = $urandom;
            end
         end
      end
   end

   initial begin
      int cnt, seen, exp_cycles;
      logic [7:0] vp;
      RSTn     = 1'b0;
      HSTART   = 1'b0;
      VPOS     = '0;
      BANK     = 1'b0;
      rom_mode = 0;
      rom_seed = 32'h5A5A_1234;
      lat      = 1;
      stray_en = 1'b0;
      clear_attr();

      repeat (3) @(posedge CL);
      #1;
      check("rst_out", 32'({SA, CREQ, CA, LA, LD, LWE, BUSY, DONE}), 32'd0);
      RSTn = 1'b1;
      @(posedge CL); #1;

      // All miss: Y=0xF0 against line 0x20
      run_line(8'h20, 1'b0, 1'b0);

      // Single sprite, then mirrored in both axes
      clear_attr();
      lat = 2;
      set_spr(5, 8'h1E, 10'h123, 3'd3, 1'b0, 1'b0, 8'h40);
      run_line(8'h20, 1'b1, 1'b0);
      set_spr(5, 8'h1E, 10'h123, 3'd3, 1'b1, 1'b1, 8'h40);
      run_line(8'h20, 1'b1, 1'b0);

      // Right-edge clipping with an all-opaque pattern
      clear_attr();
      rom_mode = 1;
      lat      = 1;
      set_spr(7, 8'h18, 10'h2A5, 3'd5, 1'b0, 1'b1, 8'hFC);
      run_line(8'h20, 1'b0, 1'b0);

      // Overlap priority plus a wrapped row (Y=250, line 4)
      clear_attr();
      rom_mode = 2;
      lat      = 3;
      set_spr(0, 8'h00, 10'h011, 3'd1, 1'b0, 1'b0, 8'h80);
      set_spr(1, 8'h02, 10'h3F0, 3'd6, 1'b1, 1'b0, 8'h80);
      set_spr(10, 8'd250, 10'h155, 3'd2, 1'b0, 1'b0, 8'h10);
      run_line(8'h04, 1'b1, 1'b0);

      // Randomized lines with stray acks; one gets a second HSTART mid-line
      stray_en = 1'b1;
      for (int t = 0; t < 6; t++) begin
         vp       = 8'($urandom);
         lat      = $urandom_range(1, 3);
         rom_seed = $urandom;
         fill_random(vp);
         run_line(vp, 1'($urandom), (t == 2));
      end
      stray_en = 1'b0;

      // Reset in the middle of drawing aborts the line silently
      clear_attr();
      rom_mode = 1;
      lat      = 2;
      set_spr(3, 8'h10, 10'h0F0, 3'd4, 1'b0, 1'b0, 8'h20);
      start_line(8'h12, 1'b0, exp_cycles);
      cnt = 0;
      while (LWE !== 1'b1 && cnt < 500) begin
         @(posedge CL); #1;
         cnt++;
      end
      check("reach_draw", 32'(LWE), 32'd1);
      #2;
      RSTn = 1'b0;
      #1;
      check("rst_lwe", 32'(LWE), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_creq", 32'(CREQ), 32'd0);
      exp_wr.delete();
      exp_ca.delete();
      @(posedge CL); #1;
      RSTn = 1'b1;
      seen = 0;
      repeat (300) begin
         @(posedge CL); #1;
         if (DONE !== 1'b0 || LWE !== 1'b0 || BUSY !== 1'b0) seen++;
      end
      check("quiet_after_rst", 32'(seen), 32'd0);

      // Normal operation resumes after the abort
      rom_mode = 0;
      set_spr(5, 8'h1E, 10'h123, 3'd3, 1'b0, 1'b0, 8'h40);
      run_line(8'h20, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
